// File: rtl/i2s_tx_seq_ctrl.sv
// I2S TX serializer channel sequencer (master mode, sck_i domain).
// Generates WS, gates the FIFO->channel handshake, preloads the channel,
// counts underruns and stops cleanly on a frame boundary.
module i2s_tx_seq_ctrl #(
  parameter int unsigned PRELOAD_WORDS = 2,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 sck_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_2ch_i,
  input  logic [4:0]           cfg_wlen_i,
  input  logic [2:0]           cfg_wnum_i,
  input  logic [31:0]          up_data_i,
  input  logic                 up_valid_i,
  output logic                 up_ready_o,
  output logic [31:0]          ch_data_o,
  output logic                 ch_valid_o,
  input  logic                 ch_ready_i,
  output logic                 ch_en_o,
  output logic                 ws_o,
  output logic                 frame_done_o,
  output logic                 underrun_o,
  output logic [ERR_CNT_W-1:0] underrun_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_RUN     = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PRELOAD_WORDS - 1);

  state_t               state_q, state_d;
  logic [4:0]           bit_q;
  logic [2:0]           word_q;
  logic [7:0]           pre_q;
  logic                 ws_q;
  logic                 ch_en_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 cfg_2ch_q;
  logic [4:0]           wlen_q;
  logic [2:0]           wnum_q;

  logic counting;
  logic last_bit;
  logic last_word;
  logic half_end;
  logic frame_end;
  logic handshake;
  logic underrun;
  logic active;

  // Lane-count shadow is held for the channel configuration; nothing here consumes it.
  logic unused_cfg_2ch;
  assign unused_cfg_2ch = cfg_2ch_q;

  // Frame position decode and handshake gating; reset blocks pops and pulses at once.
  always_comb begin
    counting   = (state_q == S_RUN) || (state_q == S_STOP);
    last_bit   = (bit_q == wlen_q);
    last_word  = (word_q == wnum_q);
    half_end   = counting && last_bit && last_word;
    frame_end  = half_end && ws_q;
    handshake  = ch_ready_i && up_valid_i;
    underrun   = counting && ch_ready_i && !up_valid_i;
    active     = (state_q != S_IDLE) && !rst_i;
  end

  assign ch_data_o      = up_data_i;
  assign ch_valid_o     = up_valid_i && active;
  assign up_ready_o     = ch_ready_i && active;
  assign frame_done_o   = frame_end && !rst_i;
  assign underrun_o     = underrun && !rst_i;
  assign ws_o           = ws_q;
  assign ch_en_o        = ch_en_q;
  assign underrun_cnt_o = err_q;
  assign busy_o         = (state_q != S_IDLE);

  // Next-state selection; re-enable in STOP resumes RUN ahead of the frame-end exit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (cfg_en_i) state_d = S_PRELOAD;
      S_PRELOAD: begin
        if (!cfg_en_i)                         state_d = S_IDLE;
        else if (handshake && pre_q == PRE_LAST) state_d = S_RUN;
      end
      S_RUN:     if (!cfg_en_i) state_d = S_STOP;
      S_STOP: begin
        if (cfg_en_i)       state_d = S_RUN;
        else if (frame_end) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // State, counters, registered WS/enable, shadow config and underrun counter.
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      word_q    <= '0;
      pre_q     <= '0;
      ws_q      <= 1'b0;
      ch_en_q   <= 1'b0;
      err_q     <= '0;
      cfg_2ch_q <= 1'b0;
      wlen_q    <= '0;
      wnum_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_en_q <= (state_d != S_IDLE);

      if ((state_d == S_RUN) || (state_d == S_STOP)) begin
        if (half_end) ws_q <= ~ws_q;
      end else begin
        ws_q <= 1'b0;
      end

      if (counting && ((state_d == S_RUN) || (state_d == S_STOP))) begin
        bit_q <= last_bit ? '0 : bit_q + 5'd1;
        if (last_bit) word_q <= last_word ? '0 : word_q + 3'd1;
      end else begin
        bit_q  <= '0;
        word_q <= '0;
      end

      if ((state_q == S_PRELOAD) && (state_d == S_PRELOAD)) begin
        if (handshake) pre_q <= pre_q + 8'd1;
      end else begin
        pre_q <= '0;
      end

      if ((state_q == S_IDLE) && (state_d == S_PRELOAD)) begin
        err_q     <= '0;
        cfg_2ch_q <= cfg_2ch_i;
        wlen_q    <= cfg_wlen_i;
        wnum_q    <= cfg_wnum_i;
      end else if (underrun && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_seq_ctrl.sv
// Directed self-checking bench for i2s_tx_seq_ctrl.
module tb_i2s_tx_seq_ctrl;

  logic        sck_i = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic        cfg_2ch_i;
  logic [4:0]  cfg_wlen_i;
  logic [2:0]  cfg_wnum_i;
  logic [31:0] up_data_i;
  logic        up_valid_i;
  logic        up_ready_o;
  logic [31:0] ch_data_o;
  logic        ch_valid_o;
  logic        ch_ready_i;
  logic        ch_en_o;
  logic        ws_o;
  logic        frame_done_o;
  logic        underrun_o;
  logic [7:0]  underrun_cnt_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  i2s_tx_seq_ctrl #(.PRELOAD_WORDS(2), .ERR_CNT_W(8)) dut (
    .sck_i          (sck_i),
    .rst_i          (rst_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_2ch_i      (cfg_2ch_i),
    .cfg_wlen_i     (cfg_wlen_i),
    .cfg_wnum_i     (cfg_wnum_i),
    .up_data_i      (up_data_i),
    .up_valid_i     (up_valid_i),
    .up_ready_o     (up_ready_o),
    .ch_data_o      (ch_data_o),
    .ch_valid_o     (ch_valid_o),
    .ch_ready_i     (ch_ready_i),
    .ch_en_o        (ch_en_o),
    .ws_o           (ws_o),
    .frame_done_o   (frame_done_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o),
    .busy_o         (busy_o)
  );

  always #5 sck_i = ~sck_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reset, then raise enable at a negedge (that negedge is k=0 for callers).
  task automatic start(input logic [4:0] wlen, input logic [2:0] wnum, input logic valid);
    rst_i      = 1'b1;
    cfg_en_i   = 1'b0;
    cfg_2ch_i  = 1'b0;
    cfg_wlen_i = wlen;
    cfg_wnum_i = wnum;
    up_valid_i = valid;
    ch_ready_i = 1'b1;
    repeat (2) @(negedge sck_i);
    rst_i    = 1'b0;
    cfg_en_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i      = 1'b1;
    cfg_en_i   = 1'b0;
    cfg_2ch_i  = 1'b1;
    cfg_wlen_i = 5'd15;
    cfg_wnum_i = 3'd0;
    up_data_i  = 32'hA5C3_0F1E;
    up_valid_i = 1'b1;
    ch_ready_i = 1'b1;
    repeat (2) @(negedge sck_i);
    checks++;
    if ({ws_o, ch_en_o, up_ready_o, ch_valid_o, frame_done_o, underrun_o, busy_o, underrun_cnt_o} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ws=%b en=%b rdy=%b vld=%b fd=%b ur=%b busy=%b cnt=%0d, expected all 0",
               ws_o, ch_en_o, up_ready_o, ch_valid_o, frame_done_o, underrun_o, busy_o, underrun_cnt_o);
    end
    checks++;
    if (ch_data_o !== 32'hA5C3_0F1E) begin
      failures++;
      $display("FAIL data_pass: got %h expected a5c30f1e", ch_data_o);
    end
  endtask

  // W=16, N=1: preload 2 words (k=1,2), RUN from k=3, WS half = 16, frame = 32.
  task automatic test_w16_n1();
    bit exp_ws, exp_fd;
    start(5'd15, 3'd0, 1'b1);
    for (int k = 1; k <= 70; k++) begin
      @(negedge sck_i);
      exp_ws = (k >= 3) && (((k - 3) / 16) % 2 == 1);
      exp_fd = (k >= 3) && ((k - 3) % 32 == 31);
      checks++;
      if ({ws_o, frame_done_o, busy_o, ch_en_o, up_ready_o} !== {exp_ws, exp_fd, 1'b1, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL w16n1 k=%0d: got ws=%b fd=%b busy=%b en=%b rdy=%b expected ws=%b fd=%b busy=1 en=1 rdy=1",
                 k, ws_o, frame_done_o, busy_o, ch_en_o, up_ready_o, exp_ws, exp_fd);
      end
    end
  endtask

  // W=8, N=4: WS toggles every 32 cycles, frame every 64.
  task automatic test_w8_n4();
    bit exp_ws, exp_fd;
    start(5'd7, 3'd3, 1'b1);
    for (int k = 1; k <= 140; k++) begin
      @(negedge sck_i);
      exp_ws = (k >= 3) && (((k - 3) / 32) % 2 == 1);
      exp_fd = (k >= 3) && ((k - 3) % 64 == 63);
      checks++;
      if ({ws_o, frame_done_o} !== {exp_ws, exp_fd}) begin
        failures++;
        $display("FAIL w8n4 k=%0d: got ws=%b fd=%b expected ws=%b fd=%b", k, ws_o, frame_done_o, exp_ws, exp_fd);
      end
    end
  endtask

  // Continues from a running W=8/N=4 stream.
  task automatic test_underrun();
    @(negedge sck_i);
    up_valid_i = 1'b0;
    #1;
    checks++;
    if ({underrun_o, up_ready_o, ch_valid_o} !== 3'b110) begin
      failures++;
      $display("FAIL underrun_pulse: got ur=%b rdy=%b vld=%b expected ur=1 rdy=1 vld=0", underrun_o, up_ready_o, ch_valid_o);
    end
    @(negedge sck_i);
    up_valid_i = 1'b1;
    #1;
    checks++;
    if ({underrun_o, underrun_cnt_o} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL underrun_count1: got ur=%b cnt=%0d expected ur=0 cnt=1", underrun_o, underrun_cnt_o);
    end
    up_valid_i = 1'b0;
    repeat (300) @(negedge sck_i);
    up_valid_i = 1'b1;
    #1;
    checks++;
    if (underrun_cnt_o !== 8'd255) begin
      failures++;
      $display("FAIL underrun_saturate: got cnt=%0d expected 255", underrun_cnt_o);
    end
    cfg_en_i = 1'b0;
    for (int i = 0; i < 200 && busy_o; i++) @(negedge sck_i);
    checks++;
    if ({busy_o, underrun_cnt_o} !== {1'b0, 8'd255}) begin
      failures++;
      $display("FAIL stop_keeps_count: got busy=%b cnt=%0d expected busy=0 cnt=255", busy_o, underrun_cnt_o);
    end
    cfg_en_i = 1'b1;
    @(negedge sck_i);
    checks++;
    if ({busy_o, underrun_cnt_o} !== {1'b1, 8'd0}) begin
      failures++;
      $display("FAIL restart_clears_count: got busy=%b cnt=%0d expected busy=1 cnt=0", busy_o, underrun_cnt_o);
    end
  endtask

  // FIFO empty during PRELOAD: channel waits, no underrun is flagged.
  task automatic test_preload_stall();
    start(5'd15, 3'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge sck_i);
      checks++;
      if ({busy_o, ch_en_o, up_ready_o, ch_valid_o, underrun_o, ws_o} !== 6'b111000) begin
        failures++;
        $display("FAIL preload_stall k=%0d: got busy=%b en=%b rdy=%b vld=%b ur=%b ws=%b expected 1 1 1 0 0 0",
                 k, busy_o, ch_en_o, up_ready_o, ch_valid_o, underrun_o, ws_o);
      end
    end
    up_valid_i = 1'b1;
    // Handshakes at the next two edges, RUN from k=7, WS rises at k=23.
    for (int k = 6; k <= 24; k++) begin
      @(negedge sck_i);
      checks++;
      if (ws_o !== (k >= 23)) begin
        failures++;
        $display("FAIL preload_then_run k=%0d: got ws=%b expected %b", k, ws_o, (k >= 23));
      end
    end
  endtask

  // Drop enable mid-frame: STOP until frame end at k=34, IDLE from k=35.
  task automatic test_stop();
    bit exp_ws, exp_fd, exp_busy;
    start(5'd15, 3'd0, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      @(negedge sck_i);
      exp_busy = (k <= 34);
      exp_ws   = (k >= 3) && (k <= 34) && (((k - 3) / 16) % 2 == 1);
      exp_fd   = (k == 34);
      checks++;
      if ({ws_o, frame_done_o, busy_o, ch_en_o, up_ready_o} !== {exp_ws, exp_fd, exp_busy, exp_busy, exp_busy}) begin
        failures++;
        $display("FAIL stop k=%0d: got ws=%b fd=%b busy=%b en=%b rdy=%b expected ws=%b fd=%b busy/en/rdy=%b",
                 k, ws_o, frame_done_o, busy_o, ch_en_o, up_ready_o, exp_ws, exp_fd, exp_busy);
      end
      if (k == 10) cfg_en_i = 1'b0;
    end
  endtask

  // Drop then re-raise enable before frame end: frames continue uninterrupted.
  task automatic test_stop_resume();
    bit exp_ws, exp_fd;
    start(5'd15, 3'd0, 1'b1);
    for (int k = 1; k <= 70; k++) begin
      @(negedge sck_i);
      exp_ws = (k >= 3) && (((k - 3) / 16) % 2 == 1);
      exp_fd = (k == 34) || (k == 66);
      checks++;
      if ({ws_o, frame_done_o, busy_o} !== {exp_ws, exp_fd, 1'b1}) begin
        failures++;
        $display("FAIL stop_resume k=%0d: got ws=%b fd=%b busy=%b expected ws=%b fd=%b busy=1",
                 k, ws_o, frame_done_o, busy_o, exp_ws, exp_fd);
      end
      if (k == 10) cfg_en_i = 1'b0;
      if (k == 20) cfg_en_i = 1'b1;
    end
  endtask

  // Change W while running: ignored until the next IDLE->PRELOAD.
  task automatic test_cfg_shadow();
    bit exp_ws, exp_fd, exp_busy;
    start(5'd15, 3'd0, 1'b1);
    for (int k = 1; k <= 140; k++) begin
      @(negedge sck_i);
      if (k <= 98) begin
        exp_busy = 1'b1;
        exp_ws   = (k >= 3) && (((k - 3) / 16) % 2 == 1);
        exp_fd   = (k >= 3) && ((k - 3) % 32 == 31);
      end else if (k == 99) begin
        exp_busy = 1'b0;
        exp_ws   = 1'b0;
        exp_fd   = 1'b0;
      end else begin
        // Restarted at k=100 with W=8: RUN from k=102, half 8, frame 16.
        exp_busy = 1'b1;
        exp_ws   = (k >= 102) && (((k - 102) / 8) % 2 == 1);
        exp_fd   = (k >= 102) && ((k - 102) % 16 == 15);
      end
      checks++;
      if ({ws_o, frame_done_o, busy_o} !== {exp_ws, exp_fd, exp_busy}) begin
        failures++;
        $display("FAIL cfg_shadow k=%0d: got ws=%b fd=%b busy=%b expected ws=%b fd=%b busy=%b",
                 k, ws_o, frame_done_o, busy_o, exp_ws, exp_fd, exp_busy);
      end
      if (k == 5)  cfg_wlen_i = 5'd7;
      if (k == 70) cfg_en_i = 1'b0;
      if (k == 99) cfg_en_i = 1'b1;
    end
  endtask

  // Reset mid-RUN with enable held: outputs clear, then a fresh 2-word preload.
  task automatic test_reset_mid_run();
    bit exp_ws, exp_fd;
    start(5'd15, 3'd0, 1'b1);
    repeat (20) @(negedge sck_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({up_ready_o, ch_valid_o, frame_done_o, underrun_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_gates_pop: got rdy=%b vld=%b fd=%b ur=%b expected all 0",
               up_ready_o, ch_valid_o, frame_done_o, underrun_o);
    end
    @(negedge sck_i);
    checks++;
    if ({ws_o, ch_en_o, up_ready_o, ch_valid_o, frame_done_o, underrun_o, busy_o, underrun_cnt_o} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid_run: got ws=%b en=%b rdy=%b vld=%b fd=%b ur=%b busy=%b cnt=%0d expected all 0",
               ws_o, ch_en_o, up_ready_o, ch_valid_o, frame_done_o, underrun_o, busy_o, underrun_cnt_o);
    end
    rst_i = 1'b0;
    // PRELOAD at k=22,23; RUN from k=24.
    for (int k = 22; k <= 60; k++) begin
      @(negedge sck_i);
      exp_ws = (k >= 24) && (((k - 24) / 16) % 2 == 1);
      exp_fd = (k >= 24) && ((k - 24) % 32 == 31);
      checks++;
      if ({ws_o, frame_done_o, busy_o, up_ready_o} !== {exp_ws, exp_fd, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL reset_restart k=%0d: got ws=%b fd=%b busy=%b rdy=%b expected ws=%b fd=%b busy=1 rdy=1",
                 k, ws_o, frame_done_o, busy_o, up_ready_o, exp_ws, exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_w16_n1();
    test_w8_n4();
    test_underrun();
    test_preload_stall();
    test_stop();
    test_stop_resume();
    test_cfg_shadow();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
